// File: rtl/full_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : full_adder                                                 |
// | Description : Registered WIDTH-bit ripple-carry adder {Cout,Sum}=A+B+Cin. |
// |               Define FULL_ADDER_OVF_EN to add the registered Ovf output.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             out_valid
`ifdef FULL_ADDER_OVF_EN
  ,
  output logic             Ovf
`endif
);

  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_out_valid;

  assign w_c[0] = Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign w_s[i]   = A[i] ^ B[i] ^ w_c[i];
    assign w_c[i+1] = (A[i] & B[i]) | (A[i] & w_c[i]) | (B[i] & w_c[i]);
  end

  // Registers only load on in_valid, so undriven operands while idle never reach the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_sum  <= w_s;
        r_cout <= w_c[WIDTH];
      end
    end
  end

  assign Sum       = r_sum;
  assign Cout      = r_cout;
  assign out_valid = r_out_valid;

`ifdef FULL_ADDER_OVF_EN
  logic r_ovf;

  // For WIDTH=1 the chain's c[0] is Cin, which is exactly the carry into the sign bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (in_valid) begin
      r_ovf <= w_c[WIDTH] ^ w_c[WIDTH-1];
    end
  end

  assign Ovf = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_full_adder.sv
`default_nettype none
// Testbench for full_adder: directed vectors on a WIDTH=1 and a WIDTH=8 instance.
module tb_full_adder;

  logic       clk;
  logic       rst_n;
  logic       v1, a1, b1, cin1;
  logic       s1, co1, ov1;
  logic       v8, cin8;
  logic [7:0] a8, b8, s8;
  logic       co8, ov8;
`ifdef FULL_ADDER_OVF_EN
  logic       ovf1, ovf8;
`endif

  int total = 0;
  int bad   = 0;

  full_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .A(a1), .B(b1), .Cin(cin1),
    .Sum(s1), .Cout(co1), .out_valid(ov1)
`ifdef FULL_ADDER_OVF_EN
    , .Ovf(ovf1)
`endif
  );

  full_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .A(a8), .B(b8), .Cin(cin8),
    .Sum(s8), .Cout(co8), .out_valid(ov8)
`ifdef FULL_ADDER_OVF_EN
    , .Ovf(ovf8)
`endif
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic test_reset;
    rst_n = 1'b0; v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    v8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    #5;
    total++;
    if ({co1, s1, ov1} !== 3'b000) begin
      bad++; $display("FAIL reset_w1: got cout/sum/valid=%b%b%b need 000", co1, s1, ov1);
    end
    total++;
    if ({co8, s8, ov8} !== 10'h000) begin
      bad++; $display("FAIL reset_w8: got cout=%b sum=%h valid=%b need 0/00/0", co8, s8, ov8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (ov1 !== 1'b0 || s1 !== 1'b0) begin
      bad++; $display("FAIL idle_after_reset: got sum=%b valid=%b need 0/0", s1, ov1);
    end
  endtask

  task automatic test_basic;
    logic [2:0] vec [3];
    logic [1:0] exp [3];
    vec[0] = 3'b010; exp[0] = 2'b01;
    vec[1] = 3'b110; exp[1] = 2'b10;
    vec[2] = 3'b111; exp[2] = 2'b11;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      {a1, b1, cin1} = vec[i]; v1 = 1'b1;
      @(posedge clk); #1;
      total++;
      if ({co1, s1} !== exp[i] || ov1 !== 1'b1) begin
        bad++;
        $display("FAIL basic_%0d: got cout,sum=%b%b valid=%b need %b valid=1", i, co1, s1, ov1, exp[i]);
      end
    end
    @(negedge clk); v1 = 1'b0;
  endtask

  // Back-to-back captures: one result per edge with out_valid held high.
  task automatic test_sweep;
    logic [2:0] bits;
    logic [1:0] exp;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bits = i[2:0];
      {a1, b1, cin1} = bits; v1 = 1'b1;
      exp = {1'b0, bits[2]} + {1'b0, bits[1]} + {1'b0, bits[0]};
      @(posedge clk); #1;
      total++;
      if ({co1, s1} !== exp || ov1 !== 1'b1) begin
        bad++;
        $display("FAIL sweep_%0d: got cout,sum=%b%b valid=%b need %b valid=1", i, co1, s1, ov1, exp);
      end
    end
    @(negedge clk); v1 = 1'b0;
  endtask

  task automatic test_width8;
    logic [16:0] vin [4];
    logic [8:0]  exp [4];
    logic        eovf [4];
    vin[0] = {8'hFF, 8'h00, 1'b1}; exp[0] = {1'b1, 8'h00}; eovf[0] = 1'b0;
    vin[1] = {8'h7F, 8'h01, 1'b0}; exp[1] = {1'b0, 8'h80}; eovf[1] = 1'b1;
    vin[2] = {8'hFF, 8'hFF, 1'b1}; exp[2] = {1'b1, 8'hFF}; eovf[2] = 1'b0;
    vin[3] = {8'h00, 8'h00, 1'b0}; exp[3] = {1'b0, 8'h00}; eovf[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      {a8, b8, cin8} = vin[i]; v8 = 1'b1;
      @(posedge clk); #1;
      total++;
      if ({co8, s8} !== exp[i] || ov8 !== 1'b1) begin
        bad++;
        $display("FAIL w8_%0d: got cout=%b sum=%h valid=%b need %b valid=1", i, co8, s8, ov8, exp[i]);
      end
`ifdef FULL_ADDER_OVF_EN
      total++;
      if (ovf8 !== eovf[i]) begin
        bad++; $display("FAIL w8_ovf_%0d: got %b need %b", i, ovf8, eovf[i]);
      end
`else
      if (eovf[i] === 1'bx) $display("unexpected x in overflow table");
`endif
    end
    @(negedge clk); v8 = 1'b0;
  endtask

  task automatic test_hold;
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b0; v1 = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({co1, s1} !== 2'b10) begin
      bad++; $display("FAIL hold_load: got cout,sum=%b%b need 10", co1, s1);
    end
    @(negedge clk);
    v1 = 1'b0; a1 = 1'bx; b1 = 1'b0; cin1 = 1'bx;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      total++;
      if ({co1, s1} !== 2'b10 || ov1 !== 1'b0) begin
        bad++; $display("FAIL hold_%0d: got cout,sum=%b%b valid=%b need 10 valid=0", i, co1, s1, ov1);
      end
    end
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; v1 = 1'b1;
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1; v8 = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({co1, s1} !== 2'b11 || s8 !== 8'h47) begin
      bad++; $display("FAIL pre_reset: got cout,sum=%b%b sum8=%h need 11 and 47", co1, s1, s8);
    end
    @(negedge clk);
    v1 = 1'b0; v8 = 1'b0;
    #2 rst_n = 1'b0;
    #2;
    total++;
    if ({co1, s1, ov1} !== 3'b000 || {co8, s8, ov8} !== 10'h000) begin
      bad++;
      $display("FAIL async_reset: got w1=%b%b%b w8 cout=%b sum=%h valid=%b need all 0", co1, s1, ov1, co8, s8, ov8);
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({co1, s1, ov1} !== 3'b000) begin
      bad++; $display("FAIL reset_stays: got %b%b%b need 000", co1, s1, ov1);
    end
    @(negedge clk);
    a1 = 1'b0; b1 = 1'b1; cin1 = 1'b1; v1 = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({co1, s1, ov1} !== 3'b101) begin
      bad++; $display("FAIL post_reset_capture: got %b%b%b need 101", co1, s1, ov1);
    end
    @(negedge clk); v1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sweep();
    test_width8();
    test_hold();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
